apb_arbiter: RTL

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port; every output is registered.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module apb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req0_write,
  input  logic [3:0]            req0_stb,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic                  req1_write,
  input  logic [3:0]            req1_stb,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic                  grant_r, grant_s;
  logic                  last_grant_r, last_grant_s;
  logic                  valid0_s, valid1_s, pick_s;
  logic [ADDR_WIDTH-1:0] paddr_s;
  logic [DATA_WIDTH-1:0] pdata_s, rdata0_s, rdata1_s, resp_rdata_s;
  logic [3:0]            pstb_s;
  logic                  pwrite_s, psel_s, penable_s, busy_s;
  logic                  done0_s, done1_s, err0_s, err1_s, resp_err_s;
  logic                  timeout_s;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r, cnt_s;

  // Counts ACCESS cycles without pready; cleared while entering ACCESS from SETUP.
  always_comb begin
    cnt_s = cnt_r;
    if (state_r == SETUP) begin
      cnt_s = {CNT_W{1'b0}};
    end else if ((state_r == ACCESS) && !pready) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Timeout counter register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign timeout_s = (state_r == ACCESS) && !pready && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output computation; a requester is masked during its own done cycle.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    paddr_s      = paddr;
    pdata_s      = pdata;
    pwrite_s     = pwrite;
    pstb_s       = pstb;
    psel_s       = psel;
    penable_s    = penable;
    busy_s       = busy;
    done0_s      = 1'b0;
    done1_s      = 1'b0;
    err0_s       = req0_err;
    err1_s       = req1_err;
    rdata0_s     = req0_rdata;
    rdata1_s     = req1_rdata;
    valid0_s     = req0_valid & ~req0_done;
    valid1_s     = req1_valid & ~req1_done;
    pick_s       = (valid0_s & valid1_s) ? ~last_grant_r : valid1_s;
    resp_err_s   = timeout_s ? 1'b1 : perr;
    if (timeout_s) begin
      resp_rdata_s = {DATA_WIDTH{1'b0}};
    end else if (pwrite) begin
      resp_rdata_s = grant_r ? req1_rdata : req0_rdata;
    end else begin
      resp_rdata_s = prdata;
    end

    case (state_r)
      IDLE: begin
        if (valid0_s | valid1_s) begin
          state_s      = SETUP;
          grant_s      = pick_s;
          last_grant_s = pick_s;
          paddr_s      = pick_s ? req1_addr : req0_addr;
          pdata_s      = pick_s ? req1_wdata : req0_wdata;
          pwrite_s     = pick_s ? req1_write : req0_write;
          pstb_s       = pwrite_s ? (pick_s ? req1_stb : req0_stb) : 4'b0000;
          psel_s       = 1'b1;
          penable_s    = 1'b0;
          busy_s       = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s   = ACCESS;
        penable_s = 1'b1;
      end
      ACCESS: begin
        if (pready || timeout_s) begin
          state_s   = IDLE;
          psel_s    = 1'b0;
          penable_s = 1'b0;
          busy_s    = 1'b0;
          if (grant_r) begin
            done1_s  = 1'b1;
            err1_s   = resp_err_s;
            rdata1_s = resp_rdata_s;
          end else begin
            done0_s  = 1'b1;
            err0_s   = resp_err_s;
            rdata0_s = resp_rdata_s;
          end
        end else begin
          state_s = ACCESS;
        end
      end
      default: begin
        state_s   = IDLE;
        psel_s    = 1'b0;
        penable_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset leaves requester 0 with first priority.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      paddr        <= {ADDR_WIDTH{1'b0}};
      pdata        <= {DATA_WIDTH{1'b0}};
      pwrite       <= 1'b0;
      pstb         <= 4'b0000;
      psel         <= 1'b0;
      penable      <= 1'b0;
      busy         <= 1'b0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req0_err     <= 1'b0;
      req1_err     <= 1'b0;
      req0_rdata   <= {DATA_WIDTH{1'b0}};
      req1_rdata   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      paddr        <= paddr_s;
      pdata        <= pdata_s;
      pwrite       <= pwrite_s;
      pstb         <= pstb_s;
      psel         <= psel_s;
      penable      <= penable_s;
      busy         <= busy_s;
      req0_done    <= done0_s;
      req1_done    <= done1_s;
      req0_err     <= err0_s;
      req1_err     <= err1_s;
      req0_rdata   <= rdata0_s;
      req1_rdata   <= rdata1_s;
    end
  end

endmodule
